alu_issue_stage: RTL and testbench

//  Producer side of the ALU operand/mode interface: decodes one RV32I instruction per beat (OP, OP-IMM,
//  LUI, AUIPC, BRANCH) plus its PC and register-file read data into in_a/in_b/alu_mode_t for execute.

---
 rtl/alu_issue_stage_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_decoder.sv | 101 ++++++++++
 rtl/alu_issue_stage.sv | 105 ++++++++++
 tb/tb_alu_issue_stage.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: RV32I opcode/funct constants, ALU mode
// encoding and the decoded beat carried from decode to execute.
package alu_issue_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NULL,
    ALU_ADD,
    ALU_SUB,
    ALU_SHIFT_LEFT,
    ALU_SHIFT_RIGHT,
    ALU_SET_LESS_THAN,
    ALU_EQUAL,
    ALU_XOR,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef struct packed {
    alu_op_t operation;
    logic    is_signed;
  } alu_mode_t;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    alu_mode_t   mode;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic        br_invert;
    logic        illegal;
  } issue_beat_t;

  localparam issue_beat_t BEAT_RESET = '0;

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decode of OP, OP-IMM, LUI, AUIPC and BRANCH into ALU
// operands and mode; anything else becomes an illegal beat with zero operands.
module alu_op_decoder
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output issue_beat_t o_beat
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic        w_is_op;
  logic        w_f7_zero;
  logic        w_f7_alt;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;

  assign w_opcode  = i_instr[6:0];
  assign w_rd      = i_instr[11:7];
  assign w_f3      = i_instr[14:12];
  assign w_f7      = i_instr[31:25];
  assign w_is_op   = (w_opcode == OPC_OP);
  assign w_f7_zero = (w_f7 == F7_ZERO);
  assign w_f7_alt  = (w_f7 == F7_ALT);
  assign w_imm_i   = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u   = {i_instr[31:12], 12'h000};

  logic        w_legal;
  alu_op_t     w_op;
  logic        w_sgn;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_br;
  logic        w_inv;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    w_legal = 1'b0;
    w_op    = ALU_NULL;
    w_sgn   = 1'b0;
    w_a     = '0;
    w_b     = '0;
    w_br    = 1'b0;
    w_inv   = 1'b0;
    if (w_is_op || (w_opcode == OPC_OP_IMM)) begin
      // OP and OP-IMM share one funct3 map; only funct7 legality and operand b differ.
      w_a = i_rs1_data;
      w_b = w_is_op ? i_rs2_data : w_imm_i;
      case (w_f3)
        F3_ADD_SUB: begin
          w_op    = (w_is_op && w_f7_alt) ? ALU_SUB : ALU_ADD;
          w_legal = !w_is_op || w_f7_zero || w_f7_alt;
        end
        F3_SLL:  begin w_op = ALU_SHIFT_LEFT;    w_legal = w_f7_zero; end
        F3_SLT:  begin w_op = ALU_SET_LESS_THAN; w_sgn = 1'b1; w_legal = !w_is_op || w_f7_zero; end
        F3_SLTU: begin w_op = ALU_SET_LESS_THAN; w_legal = !w_is_op || w_f7_zero; end
        F3_XOR:  begin w_op = ALU_XOR;           w_legal = !w_is_op || w_f7_zero; end
        F3_SR:   begin w_op = ALU_SHIFT_RIGHT;   w_sgn = w_f7[5]; w_legal = w_f7_zero || w_f7_alt; end
        F3_OR:   begin w_op = ALU_OR;            w_legal = !w_is_op || w_f7_zero; end
        default: begin w_op = ALU_AND;           w_legal = !w_is_op || w_f7_zero; end
      endcase
    end else if (w_opcode == OPC_LUI) begin
      w_b = w_imm_u; w_op = ALU_ADD; w_legal = 1'b1;
    end else if (w_opcode == OPC_AUIPC) begin
      w_a = i_pc; w_b = w_imm_u; w_op = ALU_ADD; w_legal = 1'b1;
    end else if (w_opcode == OPC_BRANCH) begin
      w_a = i_rs1_data; w_b = i_rs2_data; w_br = 1'b1; w_legal = 1'b1;
      case (w_f3)
        F3_BEQ:  begin w_op = ALU_EQUAL; end
        F3_BNE:  begin w_op = ALU_EQUAL; w_inv = 1'b1; end
        F3_BLT:  begin w_op = ALU_SET_LESS_THAN; w_sgn = 1'b1; end
        F3_BGE:  begin w_op = ALU_SET_LESS_THAN; w_sgn = 1'b1; w_inv = 1'b1; end
        F3_BLTU: begin w_op = ALU_SET_LESS_THAN; end
        F3_BGEU: begin w_op = ALU_SET_LESS_THAN; w_inv = 1'b1; end
        default: begin w_legal = 1'b0; end
      endcase
    end
  end

  always_comb begin
    o_beat    = BEAT_RESET;
    o_beat.rd = w_rd;
    if (w_legal) begin
      o_beat.op_a           = w_a;
      o_beat.op_b           = w_b;
      o_beat.mode.operation = w_op;
      o_beat.mode.is_signed = w_sgn;
      o_beat.is_branch      = w_br;
      o_beat.br_invert      = w_inv;
      o_beat.rd_we          = !w_br && (w_rd != 5'd0);
    end else begin
      o_beat.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per beat and presents it registered
// to execute, with an optional skid entry so in_ready comes straight from a flop.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int SKID_BUFFER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output alu_mode_t   out_mode,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_is_branch,
  output logic        out_br_invert,
  output logic        out_illegal
);

  localparam bit USE_SKID = (SKID_BUFFER != 0);

  issue_beat_t w_dec;
  issue_beat_t r_main;
  issue_beat_t r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_main_load;
  logic        w_skid_load;

  alu_op_decoder u_decoder (
    .i_instr    (in_instr),
    .i_pc       (in_pc),
    .i_rs1_data (in_rs1_data),
    .i_rs2_data (in_rs2_data),
    .o_beat     (w_dec)
  );

  assign w_out_fire  = r_main_valid && out_ready;
  assign w_main_load = !r_main_valid || w_out_fire;
  assign in_ready    = USE_SKID ? !r_skid_valid : w_main_load;
  assign w_in_fire   = in_valid && in_ready;
  // Without a skid entry in_ready already implies w_main_load, so this never fires.
  assign w_skid_load = USE_SKID && w_in_fire && !w_main_load;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main       <= BEAT_RESET;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_main_load) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main       <= r_skid;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main       <= w_dec;
      end else begin
        r_main_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_main_load && r_skid_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_skid_load) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is deliberately not reset; r_skid_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid <= w_dec;
    end
  end

  assign out_valid     = r_main_valid;
  assign out_op_a      = r_main.op_a;
  assign out_op_b      = r_main.op_b;
  assign out_mode      = r_main.mode;
  assign out_rd        = r_main.rd;
  assign out_rd_we     = r_main.rd_we;
  assign out_is_branch = r_main.is_branch;
  assign out_br_invert = r_main.br_invert;
  assign out_illegal   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode vectors, handshake
// scenarios and a randomized stream checked against a behavioural model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  alu_mode_t   out_mode;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_is_branch;
  logic        out_br_invert;
  logic        out_illegal;
  issue_beat_t got;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.SKID_BUFFER(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .out_mode      (out_mode),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we),
    .out_is_branch (out_is_branch),
    .out_br_invert (out_br_invert),
    .out_illegal   (out_illegal)
  );

  assign got = {out_op_a, out_op_b, out_mode, out_rd, out_rd_we, out_is_branch, out_br_invert, out_illegal};

  localparam alu_op_t REG_OPS [8] = '{ALU_ADD, ALU_SHIFT_LEFT, ALU_SET_LESS_THAN, ALU_SET_LESS_THAN,
                                      ALU_XOR, ALU_SHIFT_RIGHT, ALU_OR, ALU_AND};

  // Reference decode: table lookup of the RV32I subset, legality checked up front.
  function automatic issue_beat_t model(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
    issue_beat_t e;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        legal;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    e     = '0;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_u = {instr[31:12], 12'h000};
    legal = 1'b1;
    if (opc == 7'b0110011) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.op_a = rs1;
      e.op_b = rs2;
      e.mode.operation = (f3 == 3'd0 && f7 == 7'h20) ? ALU_SUB : REG_OPS[f3];
      e.mode.is_signed = (f3 == 3'd2) || (f3 == 3'd5 && f7 == 7'h20);
    end else if (opc == 7'b0010011) begin
      legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      e.op_a = rs1;
      e.op_b = imm_i;
      e.mode.operation = REG_OPS[f3];
      e.mode.is_signed = (f3 == 3'd2) || (f3 == 3'd5 && f7 == 7'h20);
    end else if (opc == 7'b0110111) begin
      e.op_b = imm_u;
      e.mode.operation = ALU_ADD;
    end else if (opc == 7'b0010111) begin
      e.op_a = pc;
      e.op_b = imm_u;
      e.mode.operation = ALU_ADD;
    end else if (opc == 7'b1100011) begin
      legal = (f3 != 3'd2) && (f3 != 3'd3);
      e.op_a = rs1;
      e.op_b = rs2;
      e.is_branch = 1'b1;
      e.br_invert = f3[0];
      e.mode.operation = f3[2] ? ALU_SET_LESS_THAN : ALU_EQUAL;
      e.mode.is_signed = f3[2] && !f3[1];
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e = '0;
      e.illegal = 1'b1;
    end
    e.rd = instr[11:7];
    e.rd_we = legal && !e.is_branch && (instr[11:7] != 5'd0);
    return e;
  endfunction

  function automatic issue_beat_t mk(input logic [31:0] a, input logic [31:0] b, input alu_op_t op,
                                     input logic sgn, input logic [4:0] rd, input logic we,
                                     input logic br, input logic inv, input logic ill);
    issue_beat_t e;
    e = '0;
    e.op_a = a; e.op_b = b; e.mode.operation = op; e.mode.is_signed = sgn;
    e.rd = rd; e.rd_we = we; e.is_branch = br; e.br_invert = inv; e.illegal = ill;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    opc = OPC_OP;
      2, 3:    opc = OPC_OP_IMM;
      4:       opc = OPC_LUI;
      5:       opc = OPC_AUIPC;
      6, 7:    opc = OPC_BRANCH;
      default: opc = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    n_cmp++;
    if (got !== BEAT_RESET) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, BEAT_RESET);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode_directed();
    logic [31:0] ins [4];
    logic [31:0] r1 [4];
    logic [31:0] r2 [4];
    issue_beat_t exp_b [4];
    ins = '{32'h40208133, 32'h40335293, 32'h0020D063, 32'h02208133};
    r1  = '{32'd5, 32'h80000000, 32'd7, 32'd11};
    r2  = '{32'd3, 32'h00001234, 32'd9, 32'd13};
    exp_b[0] = mk(32'd5, 32'd3, ALU_SUB, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b[1] = mk(32'h80000000, 32'h00000403, ALU_SHIFT_RIGHT, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_b[2] = mk(32'd7, 32'd9, ALU_SET_LESS_THAN, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_b[3] = mk(32'd0, 32'd0, ALU_NULL, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_pc = $urandom;
      in_rs1_data = r1[i]; in_rs2_data = r2[i];
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp_b[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got v=%b %h expected v=1 %h", i, out_valid, got, exp_b[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    logic [31:0] pcs [3];
    logic [31:0] r1 [3];
    logic [31:0] r2 [3];
    issue_beat_t exp_b [3];
    int sent;
    int recv;
    for (int i = 0; i < 3; i++) begin
      ins[i] = rand_instr(); pcs[i] = $urandom; r1[i] = $urandom; r2[i] = $urandom;
      exp_b[i] = model(ins[i], pcs[i], r1[i], r2[i]);
    end
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 3);
      if (sent < 3) begin
        in_instr = ins[sent]; in_pc = pcs[sent]; in_rs1_data = r1[sent]; in_rs2_data = r2[sent];
      end
      #1;
      if (cyc == 2) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_in_ready_after_b: got %b expected 0", in_ready);
        end
      end
      if (cyc == 5) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== exp_b[0]) begin
          n_err++;
          $display("FAIL b2b_hold: got v=%b %h expected v=1 %h", out_valid, got, exp_b[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (recv >= 3) begin
          n_err++;
          $display("FAIL b2b_duplicate: got extra beat %h expected none", got);
        end else if (got !== exp_b[recv]) begin
          n_err++;
          $display("FAIL b2b_order_%0d: got %h expected %h", recv, got, exp_b[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (recv != 3 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d beats valid=%b expected 3 beats valid=0", recv, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00500093;
    tick();
    in_instr = 32'h00a00113;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_both: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop_input: got valid=%b expected 0", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_ghost: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    issue_beat_t exp_q [$];
    issue_beat_t e;
    issue_beat_t held;
    logic        stalled;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = rand_instr();
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      #1;
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== held) begin
          n_err++;
          $display("FAIL rand_stall_hold: got v=%b %h expected v=1 %h", out_valid, got, held);
        end
      end
      n_cmp++;
      if (in_ready !== (exp_q.size() < 2)) begin
        n_err++;
        $display("FAIL rand_in_ready: got %b expected %b (held %0d)", in_ready, exp_q.size() < 2, exp_q.size());
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious: got beat %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL rand_beat: got %h expected %h", got, e);
          end
        end
      end
      if (in_valid && in_ready && !flush) exp_q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
      if (flush) exp_q.delete();
      stalled = out_valid && !out_ready && !flush;
      held = got;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_drain_spurious: got beat %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL rand_drain_beat: got %h expected %h", got, e);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d beats left expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00b50533;
    tick();
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_full: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mode !== BEAT_RESET.mode) begin
      n_err++;
      $display("FAIL reset_mid_async: got valid=%b ready=%b mode=%h expected 0 1 %h",
               out_valid, in_ready, out_mode, BEAT_RESET.mode);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_held: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_release: got valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
